// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: one boundary of the CPU pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB).
// Holds a DATA_W payload plus a CTRL_W control bundle behind a valid/ready
// handshake with stall and flush. An empty slot always shows CTRL_RST on
// out_ctrl, so downstream write/memory enables never fire on a bubble.
// Optional macro PIPE_SKID_EN adds a second (skid) entry so that in_ready
// comes from registers only and no longer depends on out_ready.
module pipe_stage_reg #(
   parameter int                 DATA_W   = 64,
   parameter int                 CTRL_W   = 16,
   parameter logic [CTRL_W-1:0]  CTRL_RST = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic              stall,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [1:0]        occupancy
);

   logic              main_valid_q, main_valid_d;
   logic [DATA_W-1:0] main_data_q,  main_data_d;
   logic [CTRL_W-1:0] main_ctrl_q,  main_ctrl_d;

   logic in_xfer;
   logic out_xfer;

   assign in_xfer  = in_valid & in_ready;
   assign out_xfer = main_valid_q & out_ready;

   assign out_valid = main_valid_q;
   assign out_data  = main_data_q;
   assign out_ctrl  = main_valid_q ? main_ctrl_q : CTRL_RST;

`ifdef PIPE_SKID_EN

   logic              skid_valid_q, skid_valid_d;
   logic [DATA_W-1:0] skid_data_q,  skid_data_d;
   logic [CTRL_W-1:0] skid_ctrl_q,  skid_ctrl_d;

   // Ready depends only on the skid flag, which breaks the out_ready path.
   assign in_ready  = ~reset & ~stall & ~skid_valid_q;
   assign occupancy = {1'b0, main_valid_q} + {1'b0, skid_valid_q};

   // Next state: skid refills main first to keep order; new beats land in
   // main when it frees up, otherwise in skid.
   always_comb begin
      main_valid_d = main_valid_q;
      main_data_d  = main_data_q;
      main_ctrl_d  = main_ctrl_q;
      skid_valid_d = skid_valid_q;
      skid_data_d  = skid_data_q;
      skid_ctrl_d  = skid_ctrl_q;
      if (flush) begin
         main_valid_d = 1'b0;
         main_ctrl_d  = CTRL_RST;
         skid_valid_d = 1'b0;
         skid_ctrl_d  = CTRL_RST;
      end else if (!main_valid_q || out_xfer) begin
         if (skid_valid_q) begin
            main_valid_d = 1'b1;
            main_data_d  = skid_data_q;
            main_ctrl_d  = skid_ctrl_q;
            skid_valid_d = 1'b0;
            skid_ctrl_d  = CTRL_RST;
         end else if (in_xfer) begin
            main_valid_d = 1'b1;
            main_data_d  = in_data;
            main_ctrl_d  = in_ctrl;
         end else if (out_xfer) begin
            main_valid_d = 1'b0;
            main_ctrl_d  = CTRL_RST;
         end
      end else if (in_xfer) begin
         skid_valid_d = 1'b1;
         skid_data_d  = in_data;
         skid_ctrl_d  = in_ctrl;
      end
   end

   // Skid entry register; reset empties it and parks the bubble control.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         skid_valid_q <= 1'b0;
         skid_data_q  <= '0;
         skid_ctrl_q  <= CTRL_RST;
      end else begin
         skid_valid_q <= skid_valid_d;
         skid_data_q  <= skid_data_d;
         skid_ctrl_q  <= skid_ctrl_d;
      end
   end

`else

   // Ready passes straight through from out_ready when the slot is full.
   assign in_ready  = ~reset & ~stall & (~main_valid_q | out_ready);
   assign occupancy = {1'b0, main_valid_q};

   // Next state: flush wins, then capture (which also covers replace), then drain.
   always_comb begin
      main_valid_d = main_valid_q;
      main_data_d  = main_data_q;
      main_ctrl_d  = main_ctrl_q;
      if (flush) begin
         main_valid_d = 1'b0;
         main_ctrl_d  = CTRL_RST;
      end else if (in_xfer) begin
         main_valid_d = 1'b1;
         main_data_d  = in_data;
         main_ctrl_d  = in_ctrl;
      end else if (out_xfer) begin
         main_valid_d = 1'b0;
         main_ctrl_d  = CTRL_RST;
      end
   end

`endif

   // Main entry register; payload is kept on drain/flush, only validity drops.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         main_valid_q <= 1'b0;
         main_data_q  <= '0;
         main_ctrl_q  <= CTRL_RST;
      end else begin
         main_valid_q <= main_valid_d;
         main_data_q  <= main_data_d;
         main_ctrl_q  <= main_ctrl_d;
      end
   end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Testbench for pipe_stage_reg: scenario tasks with inline checks plus a
// scoreboard monitor that checks every beat leaving the stage, in order.
module tb_pipe_stage_reg;

   localparam int          DATA_W   = 64;
   localparam int          CTRL_W   = 16;
   localparam logic [15:0] CTRL_RST = 16'h0000;
`ifdef PIPE_SKID_EN
   localparam bit          SKID = 1'b1;
`else
   localparam bit          SKID = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              reset;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic [CTRL_W-1:0] in_ctrl;
   logic              stall;
   logic              flush;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic [CTRL_W-1:0] out_ctrl;
   logic [1:0]        occupancy;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [CTRL_W-1:0] ctrl;
   } beat_t;

   beat_t sb[$];
   int    checks = 0;
   int    errors = 0;

   pipe_stage_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CTRL_RST(CTRL_RST)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
      .stall(stall), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
      .occupancy(occupancy)
   );

   always #5 clk = ~clk;

   // Scoreboard: at each negedge, record beats accepted at the coming edge and
   // compare beats leaving against the oldest expected one.
   always @(negedge clk) begin
      beat_t exp_b;
      if (reset) begin
         sb.delete();
      end else begin
         if (out_valid && out_ready) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("[TB] FAIL sb_unexpected: got data %h ctrl %h, expected no beat", out_data, out_ctrl);
            end else begin
               exp_b = sb.pop_front();
               if (out_data !== exp_b.data || out_ctrl !== exp_b.ctrl) begin
                  errors++;
                  $display("[TB] FAIL sb_beat: got %h/%h expected %h/%h", out_data, out_ctrl, exp_b.data, exp_b.ctrl);
               end
            end
         end
         if (flush) sb.delete();
         else if (in_valid && in_ready) sb.push_back('{data: in_data, ctrl: in_ctrl});
      end
   end

   task automatic drive_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   task automatic test_reset();
      reset = 1'b1; in_valid = 1'b0; in_data = '0; in_ctrl = '0;
      stall = 1'b0; flush = 1'b0; out_ready = 1'b1;
      sample(); sample();
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_ctrl !== CTRL_RST || out_data !== '0 || occupancy !== 2'd0) begin
         errors++;
         $display("[TB] FAIL reset_state: got rdy %b vld %b ctrl %h data %h occ %0d, expected 0 0 %h 0 0",
                  in_ready, out_valid, out_ctrl, out_data, occupancy, CTRL_RST);
      end
      drive_edge();
      reset = 1'b0;
      sample();
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL reset_release_ready: got %b expected 1", in_ready);
      end
   endtask

   task automatic test_streaming();
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         drive_edge();
         in_valid = 1'b1; in_data = 64'h10 + 64'(i); in_ctrl = 16'(i + 1);
         sample();
         checks++;
         if (in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL stream_ready[%0d]: got %b expected 1", i, in_ready);
         end
         if (i > 0) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== 64'h10 + 64'(i - 1)) begin
               errors++;
               $display("[TB] FAIL stream_out[%0d]: got vld %b data %h expected 1 %h", i, out_valid, out_data, 64'h10 + 64'(i - 1));
            end
         end
      end
      drive_edge();
      in_valid = 1'b0;
      sample();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 64'h17) begin
         errors++;
         $display("[TB] FAIL stream_last: got vld %b data %h expected 1 17", out_valid, out_data);
      end
      drive_edge();
      sample();
      checks++;
      if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
         errors++;
         $display("[TB] FAIL stream_empty: got vld %b occ %0d expected 0 0", out_valid, occupancy);
      end
   endtask

   task automatic test_back_pressure();
      logic exp_rdy;
      drive_edge();
      out_ready = 1'b0; in_valid = 1'b1; in_data = 64'hA5; in_ctrl = 16'h1111;
      sample();
      drive_edge();
      in_data = 64'hB6; in_ctrl = 16'h2222;
      for (int j = 0; j < 3; j++) begin
         sample();
         exp_rdy = SKID && (j == 0);
         checks++;
         if (out_valid !== 1'b1 || out_data !== 64'hA5 || out_ctrl !== 16'h1111 || in_ready !== exp_rdy) begin
            errors++;
            $display("[TB] FAIL bp_hold[%0d]: got vld %b data %h ctrl %h rdy %b expected 1 a5 1111 %b",
                     j, out_valid, out_data, out_ctrl, in_ready, exp_rdy);
         end
         if (j > 0) begin
            checks++;
            if (occupancy !== (SKID ? 2'd2 : 2'd1)) begin
               errors++;
               $display("[TB] FAIL bp_occ[%0d]: got %0d expected %0d", j, occupancy, SKID ? 2 : 1);
            end
         end
         drive_edge();
      end
      out_ready = 1'b1;
      in_valid  = !SKID;
      sample();
      drive_edge();
      in_valid = 1'b0;
      sample();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 64'hB6 || out_ctrl !== 16'h2222) begin
         errors++;
         $display("[TB] FAIL bp_second: got vld %b data %h ctrl %h expected 1 b6 2222", out_valid, out_data, out_ctrl);
      end
      drive_edge();
      sample();
   endtask

   task automatic test_flush();
      drive_edge();
      out_ready = 1'b0; in_valid = 1'b1; in_data = 64'hD1; in_ctrl = 16'h3333;
      drive_edge();
      in_data = 64'hD2; in_ctrl = 16'h4444;
      drive_edge();
      in_data = 64'hC7; in_ctrl = 16'h5555; flush = 1'b1;
      sample();
      checks++;
      if (occupancy !== (SKID ? 2'd2 : 2'd1) || in_ready !== 1'b0) begin
         errors++;
         $display("[TB] FAIL flush_full: got occ %0d rdy %b expected %0d 0", occupancy, in_ready, SKID ? 2 : 1);
      end
      drive_edge();
      flush = 1'b0; in_valid = 1'b0;
      sample();
      checks++;
      if (out_valid !== 1'b0 || out_ctrl !== CTRL_RST || occupancy !== 2'd0) begin
         errors++;
         $display("[TB] FAIL flush_clear: got vld %b ctrl %h occ %0d expected 0 %h 0", out_valid, out_ctrl, occupancy, CTRL_RST);
      end
      drive_edge();
      flush = 1'b1; in_valid = 1'b1;
      sample();
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL flush_empty_ready: got %b expected 1", in_ready);
      end
      drive_edge();
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      sample();
      checks++;
      if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
         errors++;
         $display("[TB] FAIL flush_drop: got vld %b occ %0d expected 0 0", out_valid, occupancy);
      end
   endtask

   task automatic test_stall();
      drive_edge();
      out_ready = 1'b0; in_valid = 1'b1; in_data = 64'h5A; in_ctrl = 16'h6666;
      drive_edge();
      stall = 1'b1; in_data = 64'h77; in_ctrl = 16'h7777;
      for (int j = 0; j < 2; j++) begin
         sample();
         checks++;
         if (in_ready !== 1'b0 || occupancy !== 2'd1 || out_data !== 64'h5A) begin
            errors++;
            $display("[TB] FAIL stall_hold[%0d]: got rdy %b occ %0d data %h expected 0 1 5a", j, in_ready, occupancy, out_data);
         end
         drive_edge();
      end
      in_valid = 1'b0; out_ready = 1'b1;
      drive_edge();
      sample();
      checks++;
      if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
         errors++;
         $display("[TB] FAIL stall_drain: got vld %b occ %0d expected 0 0", out_valid, occupancy);
      end
      drive_edge();
      stall = 1'b0;
   endtask

   task automatic test_bubble();
      out_ready = 1'b1; in_valid = 1'b1; in_data = 64'h99; in_ctrl = 16'hFFFF;
      drive_edge();
      in_valid = 1'b0;
      sample();
      checks++;
      if (out_valid !== 1'b1 || out_ctrl !== 16'hFFFF) begin
         errors++;
         $display("[TB] FAIL bubble_full: got vld %b ctrl %h expected 1 ffff", out_valid, out_ctrl);
      end
      drive_edge();
      sample();
      checks++;
      if (out_valid !== 1'b0 || out_ctrl !== CTRL_RST || out_data !== 64'h99) begin
         errors++;
         $display("[TB] FAIL bubble_empty: got vld %b ctrl %h data %h expected 0 %h 99", out_valid, out_ctrl, out_data, CTRL_RST);
      end
   endtask

   task automatic test_async_reset();
      drive_edge();
      out_ready = 1'b0; in_valid = 1'b1; in_data = 64'hEE; in_ctrl = 16'h8888;
      drive_edge();
      in_valid = 1'b0;
      sample();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 64'hEE) begin
         errors++;
         $display("[TB] FAIL areset_load: got vld %b data %h expected 1 ee", out_valid, out_data);
      end
      #2 reset = 1'b1;
      #1;
      checks++;
      if (out_valid !== 1'b0 || out_ctrl !== CTRL_RST || out_data !== '0 || occupancy !== 2'd0 || in_ready !== 1'b0) begin
         errors++;
         $display("[TB] FAIL areset_now: got vld %b ctrl %h data %h occ %0d rdy %b expected 0 %h 0 0 0",
                  out_valid, out_ctrl, out_data, occupancy, in_ready, CTRL_RST);
      end
      drive_edge();
      sample();
      drive_edge();
      reset = 1'b0; out_ready = 1'b1; in_valid = 1'b1; in_data = 64'h42; in_ctrl = 16'h0042;
      sample();
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL areset_ready: got %b expected 1", in_ready);
      end
      drive_edge();
      in_valid = 1'b0;
      sample();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 64'h42) begin
         errors++;
         $display("[TB] FAIL areset_first: got vld %b data %h expected 1 42", out_valid, out_data);
      end
   endtask

   task automatic test_drain_all();
      int budget;
      budget = 0;
      out_ready = 1'b1; in_valid = 1'b0;
      while (sb.size() != 0 && budget < 20) begin
         drive_edge();
         budget++;
      end
      sample();
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("[TB] FAIL sb_leftover: got %0d pending beats expected 0", sb.size());
      end
   endtask

   initial begin
      test_reset();
      test_streaming();
      test_back_pressure();
      test_flush();
      test_stall();
      test_bubble();
      test_async_reset();
      test_drain_all();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register for the inter-stage boundaries of the pipelined CPU (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries a DATA_W-bit datapath payload and a CTRL_W-bit control bundle, and uses a valid/ready handshake with stall and flush. Invalid slots always present a safe control value (a bubble), so downstream write and memory enables are never spuriously asserted. An optional skid entry breaks the combinational ready path between stages.

## Interface
Parameters:
- DATA_W, default 64: payload width (PC, operands, immediates, register addresses).
- CTRL_W, default 16: control bundle width (write enable, memory read/write, ALU op, branch).
- CTRL_RST, default 0: control value driven whenever the slot is empty; also the reset value.

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- in_valid  in  1  upstream beat present.
- in_ready  out  1  stage can accept a beat this cycle.
- in_data  in  DATA_W  upstream payload.
- in_ctrl  in  CTRL_W  upstream control.
- stall  in  1  blocks acceptance; in_ready forced low; output side unaffected.
- flush  in  1  discards every held beat and any beat offered this cycle.
- out_valid  out  1  beat present for downstream.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_W  held payload.
- out_ctrl  out  CTRL_W  held control; equals CTRL_RST whenever out_valid=0.
- occupancy  out  2  number of held beats (0..1, or 0..2 with skid).

## Operation
- Transfer in: in_valid & in_ready. Transfer out: out_valid & out_ready.
- Base mode: one main entry. in_ready = ~stall & (~out_valid | out_ready), so ready is combinational from out_ready.
- Accepted beat is written to the main entry, and out_valid=1 on the next cycle.
- Simultaneous out and in transfers replace the entry; no bubble is inserted.
- Out transfer with no in transfer: out_valid=0 next cycle and out_ctrl=CTRL_RST.
- Hold: while out_valid=1 and out_ready=0, out_data and out_ctrl are stable.
- flush (highest priority, synchronous): next cycle out_valid=0, out_ctrl=CTRL_RST, occupancy=0; the offered beat is dropped. in_ready is still computed normally during the flush cycle, so upstream observes a transfer, which is discarded. flush overrides stall.
- out_data is not cleared on flush or drain; only its validity changes.
- Reset: out_valid=0, out_ctrl=CTRL_RST, out_data=0, occupancy=0, skid entry empty. in_ready=0 while reset is asserted, and reflects the equations from the first cycle after release.

## Timing
- Latency: 1 cycle from in transfer to out_valid.
- Throughput: 1 beat per cycle when out_ready=1 and stall=0.
- stall asserted in cycle N: in_ready=0 in cycle N, with no capture. out_valid can still drain.
- reset mid-transfer: the beat is lost, with no partial state.

## Configuration
- PIPE_SKID_EN defined: a second skid entry is added.
  - in_ready = ~stall & ~skid_valid, taken from registers only, with no out_ready path.
  - A beat accepted while main is full and out_ready=0 goes to skid; skid_valid=1 and in_ready=0 next cycle.
  - When main drains, skid moves to main in the same edge and skid empties. Order is preserved.
  - flush clears both entries.
  - occupancy reaches 2.
- PIPE_SKID_EN undefined: base mode only; occupancy never exceeds 1.

## Test plan
- Streaming: DATA_W=64, out_ready=1, beats 0x10..0x17 on consecutive cycles -> identical values at the output 1 cycle later, with no gaps.
- Back-pressure: main holds 0xA5 and out_ready=0 for 3 cycles -> out_data stays 0xA5 and out_valid stays 1. Base mode: in_ready=0. Skid mode: one extra beat 0xB6 accepted, then in_ready=0. Release -> 0xA5 then 0xB6.
- Flush: flush with main and skid both full, plus in_valid offering 0xC7 -> next cycle out_valid=0, out_ctrl=CTRL_RST (e.g. 0x0000), occupancy=0, and 0xC7 never appears.
- Stall: stall=1 with in_valid=1 for 2 cycles -> in_ready=0 and no capture; the held beat drains when out_ready=1.
- Bubble control: after draining the last beat, with CTRL_RST=16'h0000 -> out_ctrl=0x0000 while out_valid=0, even though the previous ctrl was 0xFFFF.
- Async reset: assert reset between clock edges while the stage is full -> outputs reach reset values immediately, and the first beat after release passes through with 1-cycle latency.
